ex_mem_skid_reg: RTL and testbench

- Pipeline boundary between the EX stage (adder/ALU result, overflow flag) and the MEM stage.
- Registers the EX result bundle behind a valid/ready handshake.
- Uses a 2-entry skid buffer, so a MEM stall never combinationally back-propagates into EX in the same cycle.
- Converts an EX arithmetic overflow into a precise overflow exception: it kills that instruction's side effects and reports its PC once.

---
 rtl/ex_mem_skid_reg_pkg.sv | 14 +
 rtl/ex_mem_skid_reg_skid_entry.sv | 28 ++
 rtl/ex_mem_skid_reg.sv | 151 +++++++++++++++
 tb/tb_ex_mem_skid_reg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared widths and helpers for the EX/MEM pipeline boundary.
// The bundle is packed as {ovf, pc, write_data, mem_we, mem_re, waddr, wen, result}.
package ex_mem_skid_reg_pkg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int ENTRIES = 2;

  // Packed bundle width for a given register-address width.
  function automatic int bundle_width(input int addr_w);
    return 1 + PC_W + DATA_W + 1 + 1 + addr_w + 1 + DATA_W;
  endfunction

endpackage

// File: rtl/ex_mem_skid_reg_skid_entry.sv
// One buffer entry: a valid bit plus the packed bundle.
// Clear wins over load; data is only written on load, so an idle entry holds its contents.
module skid_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Entry register: reset zeroes everything, clear drops only the valid bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer and precise overflow exception.
// ex_ready depends only on registered state, so a MEM stall never reaches EX in the same cycle.
// Optional macro EX_MEM_FORWARD_EN adds the fwd_valid/fwd_addr/fwd_data bypass outputs.
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_overflow,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_reg_write_en,
  input  logic [ADDR_W-1:0] ex_reg_write_addr,
  input  logic              ex_mem_read_en,
  input  logic              ex_mem_write_en,
  input  logic [DATA_W-1:0] ex_mem_write_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_result,
  output logic [PC_W-1:0]   mem_pc,
  output logic              mem_reg_write_en,
  output logic [ADDR_W-1:0] mem_reg_write_addr,
  output logic              mem_mem_read_en,
  output logic              mem_mem_write_en,
  output logic [DATA_W-1:0] mem_mem_write_data,
  output logic              exc_overflow,
`ifdef EX_MEM_FORWARD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [PC_W-1:0]   exc_pc
);

  localparam int BW = bundle_width(ADDR_W);

  // The buffer is a fixed main+skid pair; any other depth is a configuration error.
  if (DEPTH != ENTRIES) begin : g_depth_check
    $error("ex_mem_skid_reg: DEPTH must be 2");
  end

  // An overflowing instruction keeps result/pc/addr but loses all architectural side effects.
  function automatic logic [BW-1:0] capture_bundle(
    input logic              ovf,
    input logic [PC_W-1:0]   pc,
    input logic [DATA_W-1:0] wdata,
    input logic              mwe,
    input logic              mre,
    input logic [ADDR_W-1:0] waddr,
    input logic              wen,
    input logic [DATA_W-1:0] result
  );
    return {ovf, pc, wdata, mwe & ~ovf, mre & ~ovf, waddr, wen & ~ovf, result};
  endfunction

  logic          main_valid;
  logic          skid_valid;
  logic [BW-1:0] main_q;
  logic [BW-1:0] skid_q;
  logic [BW-1:0] ex_bundle;
  logic [BW-1:0] main_d;
  logic          main_ovf;
  logic          accept;
  logic          pop;
  logic          load_main;
  logic          load_skid;
  logic          clr_main;
  logic          clr_skid;
  logic          main_from_skid;

  assign ex_bundle = capture_bundle(ex_overflow, ex_pc, ex_mem_write_data, ex_mem_write_en,
                                    ex_mem_read_en, ex_reg_write_addr, ex_reg_write_en,
                                    ex_result);

  assign ex_ready  = rst & ~skid_valid;
  assign mem_valid = rst & main_valid;
  assign accept    = ex_valid & ex_ready;
  assign pop       = mem_valid & mem_ready;

  // Occupancy control: decide which entry loads or clears this cycle, keeping FIFO order.
  always_comb begin
    load_main      = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    clr_skid       = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      clr_main = 1'b1;
      clr_skid = 1'b1;
    end else if (!main_valid) begin
      load_main = accept;
    end else if (skid_valid) begin
      if (pop) begin
        load_main      = 1'b1;
        main_from_skid = 1'b1;
        clr_skid       = 1'b1;
      end
    end else if (pop) begin
      if (accept) begin
        load_main = 1'b1;
      end else begin
        clr_main = 1'b1;
      end
    end else begin
      load_skid = accept;
    end
  end

  assign main_d = main_from_skid ? skid_q : ex_bundle;

  skid_entry #(.W(BW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (load_main),
    .clear (clr_main),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  skid_entry #(.W(BW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (load_skid),
    .clear (clr_skid),
    .d     (ex_bundle),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign {main_ovf, mem_pc, mem_mem_write_data, mem_mem_write_en, mem_mem_read_en,
          mem_reg_write_addr, mem_reg_write_en, mem_result} = main_q;

  assign exc_overflow = mem_valid & main_ovf & mem_ready;
  assign exc_pc       = mem_pc;

`ifdef EX_MEM_FORWARD_EN
  logic fwd_addr_nz;
  assign fwd_addr_nz = (mem_reg_write_addr != '0);
  assign fwd_valid   = mem_valid & mem_reg_write_en & fwd_addr_nz;
  assign fwd_addr    = fwd_addr_nz ? mem_reg_write_addr : '0;
  assign fwd_data    = fwd_addr_nz ? mem_result : '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed self-checking bench for ex_mem_skid_reg.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic        ex_overflow;
  logic [31:0] ex_pc;
  logic        ex_reg_write_en;
  logic [4:0]  ex_reg_write_addr;
  logic        ex_mem_read_en;
  logic        ex_mem_write_en;
  logic [31:0] ex_mem_write_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result;
  logic [31:0] mem_pc;
  logic        mem_reg_write_en;
  logic [4:0]  mem_reg_write_addr;
  logic        mem_mem_read_en;
  logic        mem_mem_write_en;
  logic [31:0] mem_mem_write_data;
  logic        exc_overflow;
  logic [31:0] exc_pc;
`ifdef EX_MEM_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.ADDR_W(5), .DEPTH(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .ex_valid           (ex_valid),
    .ex_ready           (ex_ready),
    .ex_result          (ex_result),
    .ex_overflow        (ex_overflow),
    .ex_pc              (ex_pc),
    .ex_reg_write_en    (ex_reg_write_en),
    .ex_reg_write_addr  (ex_reg_write_addr),
    .ex_mem_read_en     (ex_mem_read_en),
    .ex_mem_write_en    (ex_mem_write_en),
    .ex_mem_write_data  (ex_mem_write_data),
    .mem_valid          (mem_valid),
    .mem_ready          (mem_ready),
    .mem_result         (mem_result),
    .mem_pc             (mem_pc),
    .mem_reg_write_en   (mem_reg_write_en),
    .mem_reg_write_addr (mem_reg_write_addr),
    .mem_mem_read_en    (mem_mem_read_en),
    .mem_mem_write_en   (mem_mem_write_en),
    .mem_mem_write_data (mem_mem_write_data),
    .exc_overflow       (exc_overflow),
`ifdef EX_MEM_FORWARD_EN
    .fwd_valid          (fwd_valid),
    .fwd_addr           (fwd_addr),
    .fwd_data           (fwd_data),
`endif
    .exc_pc             (exc_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] res, input logic ovf,
                        input logic [31:0] pc, input logic wen, input logic [4:0] addr,
                        input logic re, input logic we, input logic [31:0] wd);
    ex_valid          = v;
    ex_result         = res;
    ex_overflow       = ovf;
    ex_pc             = pc;
    ex_reg_write_en   = wen;
    ex_reg_write_addr = addr;
    ex_mem_read_en    = re;
    ex_mem_write_en   = we;
    ex_mem_write_data = wd;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);

    // Reset state
    tick();
    tick();
    check("rst_ex_ready", ex_ready, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_exc", exc_overflow, 0);
    check("rst_result", mem_result, 0);
    rst = 1'b1;
    #1;
    check("post_rst_ex_ready", ex_ready, 1);

    // Back-to-back flow
    mem_ready = 1'b1;
    set_ex(1'b1, 32'h1, 1'b0, 32'h1000, 1'b1, 5'd3, 1'b1, 1'b0, 32'hDEAD0001);
    tick();
    check("b2b_valid1", mem_valid, 1);
    check("b2b_res1", mem_result, 32'h1);
    check("b2b_wen1", mem_reg_write_en, 1);
    check("b2b_re1", mem_mem_read_en, 1);
    check("b2b_wd1", mem_mem_write_data, 32'hDEAD0001);
    check("b2b_ready1", ex_ready, 1);
    set_ex(1'b1, 32'h2, 1'b0, 32'h1004, 1'b0, 5'd4, 1'b0, 1'b1, 32'hDEAD0002);
    tick();
    check("b2b_res2", mem_result, 32'h2);
    check("b2b_we2", mem_mem_write_en, 1);
    check("b2b_ready2", ex_ready, 1);
    set_ex(1'b1, 32'h3, 1'b0, 32'h1008, 1'b0, 5'd5, 1'b0, 1'b0, 32'h0);
    tick();
    check("b2b_res3", mem_result, 32'h3);
    check("b2b_pc3", mem_pc, 32'h1008);
    check("b2b_valid3", mem_valid, 1);
    ex_valid = 1'b0;
    tick();
    check("b2b_drain", mem_valid, 0);

    // Stall / skid
    mem_ready = 1'b0;
    set_ex(1'b1, 32'hA, 1'b0, 32'h2000, 1'b0, 5'd1, 1'b0, 1'b0, 32'h0);
    tick();
    check("skid_a_res", mem_result, 32'hA);
    check("skid_a_ready", ex_ready, 1);
    set_ex(1'b1, 32'hB, 1'b0, 32'h2004, 1'b0, 5'd2, 1'b0, 1'b0, 32'h0);
    tick();
    check("skid_full_ready", ex_ready, 0);
    check("skid_hold_a", mem_result, 32'hA);
    ex_valid = 1'b0;
    tick();
    check("skid_stall_hold", mem_result, 32'hA);
    check("skid_stall_ready", ex_ready, 0);
    mem_ready = 1'b1;
    tick();
    check("skid_b_res", mem_result, 32'hB);
    check("skid_b_pc", mem_pc, 32'h2004);
    check("skid_b_ready", ex_ready, 1);
    tick();
    check("skid_empty", mem_valid, 0);

    // Overflow kill and precise exception
    mem_ready = 1'b0;
    set_ex(1'b1, 32'h77, 1'b1, 32'hBFC00010, 1'b1, 5'd5, 1'b1, 1'b1, 32'h5);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    check("ovf_wen_killed", mem_reg_write_en, 0);
    check("ovf_re_killed", mem_mem_read_en, 0);
    check("ovf_we_killed", mem_mem_write_en, 0);
    check("ovf_addr_kept", mem_reg_write_addr, 5);
    check("ovf_res_kept", mem_result, 32'h77);
    check("ovf_no_exc_stalled", exc_overflow, 0);
    mem_ready = 1'b1;
    #1;
    check("ovf_exc_pulse", exc_overflow, 1);
    check("ovf_exc_pc", exc_pc, 32'hBFC00010);
    tick();
    check("ovf_exc_done", exc_overflow, 0);
    check("ovf_popped", mem_valid, 0);

    // Flush with full buffer and simultaneous ex_valid
    mem_ready = 1'b0;
    set_ex(1'b1, 32'h10, 1'b0, 32'h3000, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    ex_result = 32'h20;
    tick();
    check("flush_full", ex_ready, 0);
    flush = 1'b1;
    ex_result = 32'h30;
    tick();
    flush = 1'b0;
    ex_valid = 1'b0;
    check("flush_mem_valid", mem_valid, 0);
    check("flush_ex_ready", ex_ready, 1);
    tick();
    check("flush_absent", mem_valid, 0);

    // Flush while main-only with an accept that must be dropped
    set_ex(1'b1, 32'h40, 1'b0, 32'h3100, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    flush = 1'b1;
    ex_result = 32'h50;
    tick();
    flush = 1'b0;
    ex_valid = 1'b0;
    check("flush_drop_accept", mem_valid, 0);
    check("flush_drop_ready", ex_ready, 1);

    // Flush does not suppress the exception of a popped faulting head
    set_ex(1'b1, 32'h66, 1'b1, 32'h3200, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    flush = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("flush_exc", exc_overflow, 1);
    check("flush_exc_pc", exc_pc, 32'h3200);
    tick();
    flush = 1'b0;
    check("flush_exc_cleared", mem_valid, 0);

    // Reset mid-operation with a faulting head and a full buffer
    mem_ready = 1'b0;
    set_ex(1'b1, 32'h61, 1'b1, 32'h100, 1'b1, 5'd9, 1'b0, 1'b0, 32'hAB);
    tick();
    set_ex(1'b1, 32'h62, 1'b0, 32'h104, 1'b1, 5'd10, 1'b0, 1'b0, 32'hCD);
    tick();
    check("rstmid_full", ex_ready, 0);
    ex_valid = 1'b0;
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rstmid_mem_valid", mem_valid, 0);
    check("rstmid_exc", exc_overflow, 0);
    check("rstmid_ex_ready", ex_ready, 0);
    tick();
    check("rstmid_res", mem_result, 0);
    check("rstmid_pc", mem_pc, 0);
    check("rstmid_addr", mem_reg_write_addr, 0);
    check("rstmid_wd", mem_mem_write_data, 0);
    rst = 1'b1;
    #1;
    check("rstmid_ready_back", ex_ready, 1);
    set_ex(1'b1, 32'h99, 1'b0, 32'h200, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    check("resume_valid", mem_valid, 1);
    check("resume_res", mem_result, 32'h99);
    tick();
    check("resume_drain", mem_valid, 0);

`ifdef EX_MEM_FORWARD_EN
    // Forwarding gated on address zero
    mem_ready = 1'b0;
    set_ex(1'b1, 32'h55, 1'b0, 32'h300, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    check("fwd_addr0_valid", fwd_valid, 0);
    check("fwd_addr0_data", fwd_data, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    set_ex(1'b1, 32'h55, 1'b0, 32'h304, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    check("fwd_valid", fwd_valid, 1);
    check("fwd_addr", fwd_addr, 7);
    check("fwd_data", fwd_data, 32'h55);
    mem_ready = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
